firebird7_in_gate1_tessent_tdr_w19: RTL
=======================================

# firebird7_in_gate1_tessent_tdr_w19

IJTAG test data register that drives the select and data inputs of the 19-bit gate1 data mux. The host network loads it serially through the `ijtag_si`/`ijtag_so` chain. It holds a shadow update register that is presented to the mux. Each capture returns the live functional data and a sticky shift-length error bit, so host software can observe the functional value and detect corrupted loads.

## Interface
- `DATA_WIDTH`, 19: width of the mux data path. Shift length is `LEN = DATA_WIDTH+1`.
- `ijtag_tck` in 1: TCK; all state updates on the rising edge.
- `ijtag_reset` in 1: synchronous, active-high reset.
- `ijtag_sel` in 1: TDR selected; it gates capture, shift and update.
- `ijtag_ce` in 1: capture enable.
- `ijtag_se` in 1: shift enable.
- `ijtag_ue` in 1: update enable.
- `ijtag_si` in 1: scan in.
- `ijtag_so` out 1: scan out, equal to `shift_reg[0]`. Combinational from the flop; no negedge retiming in this block.
- `functional_data_in` in DATA_WIDTH: observe value captured into the chain.
- `ijtag_data_out` out DATA_WIDTH: update-register data, wired to the mux `ijtag_data_in`.
- `ijtag_select_out` out 1: update-register select bit, wired to the mux `ijtag_select`.
- `len_err` out 1: sticky shift-length error flag.

## Operation
- **State**
  - `shift_reg[LEN-1:0]`: bit `LEN-1` is the select slot; bits `[DATA_WIDTH-1:0]` are the data slots.
  - Update register `{sel_q, data_q}`.
  - `shift_cnt`, width `$clog2(LEN+1)+1`, saturating at its maximum.
  - `len_err`.
- **Reset** (`ijtag_reset`=1 at an edge) clears everything to 0:
  - `ijtag_data_out`=0, `ijtag_select_out`=0 (mux passes functional data), `len_err`=0, `ijtag_so`=0.
  - Reset overrides any simultaneous ce/se/ue. A reset in the middle of a shift discards partial contents.
- **Capture**: `sel & ce`.
  - `shift_reg <= {len_err, functional_data_in}`.
  - `shift_cnt <= 0`.
  - `len_err` is cleared, unless an error is being set in the same cycle.
- **Shift**: `sel & se & !ce`.
  - `shift_reg <= {ijtag_si, shift_reg[LEN-1:1]}`.
  - `shift_cnt` increments, saturating.
  - ce has priority over se.
- **Update**: `sel & ue`. Evaluated on pre-edge values of `shift_reg` and `shift_cnt`.
  - If `shift_cnt == LEN`: `{sel_q, data_q} <= shift_reg`.
  - Otherwise: the update register is unchanged and `len_err <= 1`.
  - A same-cycle shift or capture does not affect the update value.
- **Error priority**: if a failing update coincides with capture, the captured bit is the old `len_err` and `len_err` ends at 1 (set wins over clear).
- **Deselected**: with `ijtag_sel`=0 all state holds and `ijtag_so` keeps presenting `shift_reg[0]`.
- **Scan order**: the word is shifted LSB first as `{select, data[18:0]}`. `data[0]` enters first, the select bit enters last.

## Timing
- Single-cycle reaction: ce/se/ue sampled at edge N take effect at edge N.
- `ijtag_so` reflects the new `shift_reg[0]` after each shift edge.
- Update to mux: `ijtag_data_out`/`ijtag_select_out` change at the update edge, so the mux output changes that same cycle (combinational mux).
- Mid-shift, the mux outputs are stable; only the update edge changes them.
- Counter saturation: shifting more than LEN bits leaves `shift_cnt > LEN`, so the update is rejected. It never wraps back to LEN.

## Structure
- Package `firebird7_in_gate1_tessent_tdr_pkg` holds:
  - localparams `LEN` and `CNT_W`;
  - function `tdr_len_ok(cnt)`.
- Single module, no sub-module. The counter and error logic are simple enough to stay inline.
- The top level instantiates this block beside `firebird7_in_gate1_tessent_data_mux_w19_22`, with `ijtag_data_out` driving mux `ijtag_data_in` and `ijtag_select_out` driving mux `ijtag_select`.

## Test plan
- **Reset and outputs:** assert reset 2 cycles with ce/se/ue high, then deassert → all outputs 0 and `len_err`=0.
- **Load:**
  - Stimulus: capture, shift exactly 20 bits of `{1'b1, 19'h5A5A5}` LSB first, then update.
  - Response: `ijtag_select_out`=1 and `ijtag_data_out`=19'h5A5A5 at the update edge. Mux output equals 19'h5A5A5.
- **Observe:**
  - Stimulus: `functional_data_in`=19'h7_0F0F, then capture and shift 20.
  - Response: `ijtag_so` yields 19'h70F0F LSB first, followed by 0 (the `len_err` bit).
- **Short shift:**
  - Stimulus: from the loaded state above, capture, shift 19 bits of all-zero, then update.
  - Response: outputs stay at 1/19'h5A5A5 and `len_err`=1.
  - Follow-up: the next capture plus 20 shifts returns MSB=1, and `len_err` is 0 after that capture.
- **Over-shift / saturation:** capture, shift 40 bits, update → update rejected and `len_err`=1.
- **Simultaneous events:**
  - Case 1 — stimulus: se and ue in the same cycle with `shift_cnt`=20. Response: the update loads the pre-shift contents.
  - Case 2 — stimulus: ce with a failing ue. Response: the captured bit is the old `len_err` and `len_err`=1 afterwards.
  - Case 3 — stimulus: any ce/se/ue with `sel`=0. Response: all state holds.

Source files
------------

// File: rtl/firebird7_in_gate1_tessent_tdr_pkg.sv
// Shared sizing and helpers for the gate1 IJTAG test data register.
// Chain length is one select slot plus the mux data width.
package firebird7_in_gate1_tessent_tdr_pkg;

    localparam int DATA_W = 19;
    localparam int LEN    = DATA_W + 1;
    localparam int CNT_W  = $clog2(LEN + 1) + 1;

    // Only a shift of exactly LEN bits since the last capture is a valid load.
    function automatic logic tdr_len_ok(input logic [CNT_W-1:0] cnt);
        return cnt == CNT_W'(LEN);
    endfunction

endpackage

// File: rtl/firebird7_in_gate1_tessent_tdr_w19.sv
// IJTAG TDR driving select/data of the gate1 19-bit mux, with sticky shift-length error.
// Latency: capture/shift/update take effect at the sampling TCK edge; so is straight from the flop.
// Backpressure: none; the host owns the chain timing, bad-length updates are dropped and flagged.
module firebird7_in_gate1_tessent_tdr_w19
    import firebird7_in_gate1_tessent_tdr_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W
) (
    input  logic                  ijtag_tck,
    input  logic                  ijtag_reset,
    input  logic                  ijtag_sel,
    input  logic                  ijtag_ce,
    input  logic                  ijtag_se,
    input  logic                  ijtag_ue,
    input  logic                  ijtag_si,
    output logic                  ijtag_so,
    input  logic [DATA_WIDTH-1:0] functional_data_in,
    output logic [DATA_WIDTH-1:0] ijtag_data_out,
    output logic                  ijtag_select_out,
    output logic                  len_err
);

    logic [LEN-1:0]        shift_reg;
    logic [CNT_W-1:0]      shift_cnt;
    logic                  sel_q;
    logic [DATA_WIDTH-1:0] data_q;

    logic cap;
    logic shf;
    logic upd;
    logic upd_ok;

    assign cap    = ijtag_sel & ijtag_ce;
    assign shf    = ijtag_sel & ijtag_se & ~ijtag_ce;
    assign upd    = ijtag_sel & ijtag_ue;
    assign upd_ok = upd & tdr_len_ok(shift_cnt);

    always_ff @(posedge ijtag_tck) begin
        if (ijtag_reset) begin
            shift_reg <= '0;
            shift_cnt <= '0;
            sel_q     <= 1'b0;
            data_q    <= '0;
            len_err   <= 1'b0;
        end else begin
            if (cap) begin
                shift_reg <= {len_err, functional_data_in};
                shift_cnt <= '0;
            end else if (shf) begin
                shift_reg <= {ijtag_si, shift_reg[LEN-1:1]};
                // Saturate so an over-long shift can never wrap back to a valid length.
                if (shift_cnt != '1)
                    shift_cnt <= shift_cnt + CNT_W'(1);
            end

            // Update samples the pre-edge chain, so a same-cycle shift/capture is invisible to it.
            if (upd_ok)
                {sel_q, data_q} <= shift_reg;

            if (upd && !upd_ok)
                len_err <= 1'b1;
            else if (cap)
                len_err <= 1'b0;
        end
    end

    assign ijtag_so         = shift_reg[0];
    assign ijtag_data_out   = data_q;
    assign ijtag_select_out = sel_q;

endmodule
